adc3424_sysref_seq: RTL and testbench

- Sequences the SYSREF pulse stream to the ADC3424 devices on the mDOM mainboard.
- Generates pulse-train D1/D2 levels in the enc_clk domain. These levels feed the SYSRF forwarding ODDR -> OBUFDS path.
- Supports one-shot bursts of N pulses and continuous periodic SYSREF, with a start/stop control handshake from the slow-control register block.

---
 rtl/adc3424_sysref_seq.sv | 209 ++++++++++++++++++++
 tb/tb_adc3424_sysref_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc3424_sysref_seq.sv
// SYSREF pulse-train sequencer for the ADC3424 ODDR forwarding path (one-shot burst or continuous).
// Define SYSREF_SEQ_ALIGN_EN to add sync_in and an ARM state that waits for a synchronised sync_in rise.
module adc3424_sysref_seq #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             enc_clk,
   input  logic             rst_n,
`ifdef SYSREF_SEQ_ALIGN_EN
   input  logic             sync_in,
`endif
   input  logic [DIV_W-1:0] cfg_period,
   input  logic [DIV_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_npulses,
   input  logic             cfg_continuous,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_count,
   output logic             sysref_d1,
   output logic             sysref_d2
);

`ifdef SYSREF_SEQ_ALIGN_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_HIGH = 3'd2, ST_LOW = 3'd3, ST_FINISH = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_HIGH = 3'd2, ST_LOW = 3'd3, ST_FINISH = 3'd4
   } state_t;
`endif

   state_t           state_r;
   logic [DIV_W-1:0] period_r;
   logic [DIV_W-1:0] high_r;
   logic [CNT_W-1:0] npulses_r;
   logic             continuous_r;
   logic [DIV_W-1:0] cnt_r;
   logic             stop_pend_r;
   logic [DIV_W-1:0] period_s;
   logic [DIV_W-1:0] high_s;

   // Clamp the live configuration so the shadow copy always describes a legal waveform
   always_comb begin
      period_s = cfg_period;
      high_s   = cfg_high;
      if (cfg_period < DIV_W'(2)) begin
         period_s = DIV_W'(2);
      end else begin
         period_s = cfg_period;
      end
      if (cfg_high == {DIV_W{1'b0}}) begin
         high_s = DIV_W'(1);
      end else if (cfg_high >= period_s) begin
         high_s = period_s - DIV_W'(1);
      end else begin
         high_s = cfg_high;
      end
   end

`ifdef SYSREF_SEQ_ALIGN_EN
   logic sync1_r, sync2_r, sync3_r;
   logic sync_rise_s;

   // Two-flop resynchroniser plus one delayed copy for rising-edge detection
   always_ff @(posedge enc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= sync_in;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign sync_rise_s = sync2_r & ~sync3_r;
`endif

   // Sequencer FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge enc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         period_r     <= {DIV_W{1'b0}};
         high_r       <= {DIV_W{1'b0}};
         npulses_r    <= {CNT_W{1'b0}};
         continuous_r <= 1'b0;
         cnt_r        <= {DIV_W{1'b0}};
         stop_pend_r  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pulse_count  <= {CNT_W{1'b0}};
         sysref_d1    <= 1'b0;
         sysref_d2    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start && !stop) begin
                  period_r     <= period_s;
                  high_r       <= high_s;
                  npulses_r    <= cfg_npulses;
                  continuous_r <= cfg_continuous;
                  stop_pend_r  <= 1'b0;
                  pulse_count  <= {CNT_W{1'b0}};
                  if (!cfg_continuous && (cfg_npulses == {CNT_W{1'b0}})) begin
                     state_r <= ST_FINISH;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
`ifdef SYSREF_SEQ_ALIGN_EN
                     state_r <= ST_ARM;
                     busy    <= 1'b1;
`else
                     state_r     <= ST_HIGH;
                     busy        <= 1'b1;
                     sysref_d1   <= 1'b1;
                     sysref_d2   <= 1'b1;
                     pulse_count <= CNT_W'(1);
                     cnt_r       <= high_s - DIV_W'(1);
`endif
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
`ifdef SYSREF_SEQ_ALIGN_EN
            ST_ARM: begin
               if (stop) begin
                  state_r <= ST_FINISH;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end else if (sync_rise_s) begin
                  state_r     <= ST_HIGH;
                  sysref_d1   <= 1'b1;
                  sysref_d2   <= 1'b1;
                  pulse_count <= CNT_W'(1);
                  cnt_r       <= high_r - DIV_W'(1);
               end else begin
                  state_r <= ST_ARM;
               end
            end
`endif
            ST_HIGH: begin
               if (stop) begin
                  stop_pend_r <= 1'b1;
               end else begin
                  stop_pend_r <= stop_pend_r;
               end
               // A stop seen during HIGH is honoured only once the pulse is complete
               if (cnt_r == {DIV_W{1'b0}}) begin
                  sysref_d1 <= 1'b0;
                  sysref_d2 <= 1'b0;
                  if (stop || stop_pend_r) begin
                     state_r     <= ST_FINISH;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     stop_pend_r <= 1'b0;
                  end else begin
                     state_r <= ST_LOW;
                     cnt_r   <= period_r - high_r - DIV_W'(1);
                  end
               end else begin
                  cnt_r <= cnt_r - DIV_W'(1);
               end
            end
            ST_LOW: begin
               if (stop) begin
                  state_r <= ST_FINISH;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end else if (cnt_r == {DIV_W{1'b0}}) begin
                  if (!continuous_r && (pulse_count == npulses_r)) begin
                     state_r <= ST_FINISH;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state_r   <= ST_HIGH;
                     sysref_d1 <= 1'b1;
                     sysref_d2 <= 1'b1;
                     cnt_r     <= high_r - DIV_W'(1);
                     if (pulse_count != {CNT_W{1'b1}}) begin
                        pulse_count <= pulse_count + CNT_W'(1);
                     end else begin
                        pulse_count <= pulse_count;
                     end
                  end
               end else begin
                  cnt_r <= cnt_r - DIV_W'(1);
               end
            end
            ST_FINISH: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               busy      <= 1'b0;
               sysref_d1 <= 1'b0;
               sysref_d2 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc3424_sysref_seq.sv
// Directed self-checking bench for adc3424_sysref_seq; covers sync_in alignment when SYSREF_SEQ_ALIGN_EN is defined.
module tb_adc3424_sysref_seq;
   localparam int DIV_W = 8;
   localparam int CNT_W = 8;

   logic             enc_clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [DIV_W-1:0] cfg_period = 8'd0;
   logic [DIV_W-1:0] cfg_high = 8'd0;
   logic [CNT_W-1:0] cfg_npulses = 8'd0;
   logic             cfg_continuous = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             busy, done, sysref_d1, sysref_d2;
   logic [CNT_W-1:0] pulse_count;
`ifdef SYSREF_SEQ_ALIGN_EN
   logic             sync_in = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   adc3424_sysref_seq #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .enc_clk(enc_clk),
      .rst_n(rst_n),
`ifdef SYSREF_SEQ_ALIGN_EN
      .sync_in(sync_in),
`endif
      .cfg_period(cfg_period),
      .cfg_high(cfg_high),
      .cfg_npulses(cfg_npulses),
      .cfg_continuous(cfg_continuous),
      .start(start),
      .stop(stop),
      .busy(busy),
      .done(done),
      .pulse_count(pulse_count),
      .sysref_d1(sysref_d1),
      .sysref_d2(sysref_d2)
   );

   always #5 enc_clk = ~enc_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge enc_clk);
      @(negedge enc_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_count", 32'(pulse_count), 32'd0);
      check("rst_d1", 32'(sysref_d1), 32'd0);
      check("rst_d2", 32'(sysref_d2), 32'd0);
      rst_n = 1'b1;
      tick();

`ifndef SYSREF_SEQ_ALIGN_EN
      // One-shot 8/3 x4, with a cfg change and a start pulse while busy
      cfg_period = 8'd8; cfg_high = 8'd3; cfg_npulses = 8'd4; cfg_continuous = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("os_d1", 32'(sysref_d1), ((i % 8) < 3) ? 32'd1 : 32'd0);
         check("os_d2", 32'(sysref_d2), ((i % 8) < 3) ? 32'd1 : 32'd0);
         check("os_busy", 32'(busy), 32'd1);
         check("os_done", 32'(done), 32'd0);
         check("os_count", 32'(pulse_count), 32'(i / 8 + 1));
         if (i == 10) begin
            cfg_period = 8'd20;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      check("os_end_done", 32'(done), 32'd1);
      check("os_end_busy", 32'(busy), 32'd0);
      check("os_end_d1", 32'(sysref_d1), 32'd0);
      check("os_end_count", 32'(pulse_count), 32'd4);
      tick();
      check("os_after_done", 32'(done), 32'd0);
      check("os_after_busy", 32'(busy), 32'd0);
      check("os_after_count", 32'(pulse_count), 32'd4);

      // Clamp: period 1 -> 2, high 5 -> 1
      cfg_period = 8'd1; cfg_high = 8'd5; cfg_npulses = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("clamp_d1", 32'(sysref_d1), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("clamp_done", 32'(done), 32'd0);
         tick();
      end
      check("clamp_end_done", 32'(done), 32'd1);
      check("clamp_end_count", 32'(pulse_count), 32'd2);
      check("clamp_end_d1", 32'(sysref_d1), 32'd0);
      tick();

      // Continuous 10/5, stop during 2nd cycle of 3rd high phase
      cfg_period = 8'd10; cfg_high = 8'd5; cfg_npulses = 8'd1; cfg_continuous = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         check("cont_d1", 32'(sysref_d1), ((i % 10) < 5) ? 32'd1 : 32'd0);
         check("cont_busy", 32'(busy), 32'd1);
         check("cont_done", 32'(done), 32'd0);
         stop = (i == 21) ? 1'b1 : 1'b0;
         tick();
      end
      stop = 1'b0;
      check("cont_end_done", 32'(done), 32'd1);
      check("cont_end_busy", 32'(busy), 32'd0);
      check("cont_end_d1", 32'(sysref_d1), 32'd0);
      check("cont_end_count", 32'(pulse_count), 32'd3);
      tick();
      check("cont_after_done", 32'(done), 32'd0);
      check("cont_after_d1", 32'(sysref_d1), 32'd0);
      cfg_continuous = 1'b0;

      // Zero pulses: immediate done, no edge
      cfg_period = 8'd8; cfg_high = 8'd3; cfg_npulses = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_d1", 32'(sysref_d1), 32'd0);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_count", 32'(pulse_count), 32'd0);
      tick();
      check("zero_after_done", 32'(done), 32'd0);
      check("zero_after_d1", 32'(sysref_d1), 32'd0);

      // start+stop together in IDLE: stop wins
      cfg_npulses = 8'd4;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("ss_busy", 32'(busy), 32'd0);
      check("ss_d1", 32'(sysref_d1), 32'd0);
      check("ss_done", 32'(done), 32'd0);
      tick();
      check("ss_busy2", 32'(busy), 32'd0);
      check("ss_d1_2", 32'(sysref_d1), 32'd0);

      // Asynchronous reset mid-HIGH
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("arst_pre_d1", 32'(sysref_d1), 32'd1);
      check("arst_pre_count", 32'(pulse_count), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_d1", 32'(sysref_d1), 32'd0);
      check("arst_d2", 32'(sysref_d2), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_count", 32'(pulse_count), 32'd0);
      tick();
      check("arst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();
      check("arst_idle_busy", 32'(busy), 32'd0);
`else
      // Aligned start: first high 3 cycles after the sync_in rise
      cfg_period = 8'd8; cfg_high = 8'd3; cfg_npulses = 8'd1; cfg_continuous = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("arm_busy", 32'(busy), 32'd1);
         check("arm_d1", 32'(sysref_d1), 32'd0);
         tick();
      end
      sync_in = 1'b1;
      tick();
      check("al_d1_c1", 32'(sysref_d1), 32'd0);
      tick();
      check("al_d1_c2", 32'(sysref_d1), 32'd0);
      tick();
      check("al_d1_c3", 32'(sysref_d1), 32'd1);
      check("al_count", 32'(pulse_count), 32'd1);
      sync_in = 1'b0;
      for (int i = 1; i < 8; i++) begin
         tick();
         check("al_run_d1", 32'(sysref_d1), (i < 3) ? 32'd1 : 32'd0);
      end
      tick();
      check("al_end_done", 32'(done), 32'd1);
      check("al_end_count", 32'(pulse_count), 32'd1);
      tick();

      // Stop while armed
      start = 1'b1;
      tick();
      start = 1'b0;
      check("arm2_busy", 32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("armstop_done", 32'(done), 32'd1);
      check("armstop_busy", 32'(busy), 32'd0);
      check("armstop_count", 32'(pulse_count), 32'd0);
      check("armstop_d1", 32'(sysref_d1), 32'd0);
      tick();
      check("armstop_after_done", 32'(done), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
